// File: rtl/sampdriver_pkg.sv
// Shared types, default sizes and the start-time configuration check for sampdriver_tdm.
package sampdriver_pkg;

   localparam int DEF_NCH   = 4;
   localparam int DEF_CNT_W = 8;
   localparam int DEF_DT_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STOP
   } state_e;

   // Operands arrive zero-extended; the sums are formed wider than any legal frame length.
   function automatic logic cfg_valid(input logic [31:0] period,
                                      input logic [31:0] width,
                                      input logic [31:0] dead,
                                      input logic        mask_nz);
      logic [33:0] need;
      logic [33:0] frame_len;
      need      = {2'b00, width} + {1'b0, dead, 1'b0};
      frame_len = {2'b00, period} + 34'd1;
      return (width != 32'd0) && mask_nz && (need <= frame_len);
   endfunction

endpackage

// File: rtl/samp_rr_ptr.sv
// Round-robin step: next set bit of mask_i above the one-hot cur_i, wrapping to the lowest.
// cur_i = 0 yields the lowest set bit of mask_i.
module samp_rr_ptr
   import sampdriver_pkg::*;
#(
   parameter int NCH = DEF_NCH
) (
   input  logic [NCH-1:0] mask_i,
   input  logic [NCH-1:0] cur_i,
   output logic [NCH-1:0] next_o
);

   localparam logic [NCH-1:0] ONE = NCH'(1);

   logic [NCH-1:0] above;
   logic [NCH-1:0] above_lsb;
   logic [NCH-1:0] mask_lsb;

   // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
   always_comb begin
      above     = mask_i & ~((cur_i << 1) - ONE);
      above_lsb = above & (~above + ONE);
      mask_lsb  = mask_i & (~mask_i + ONE);
      next_o    = (above != '0) ? above_lsb : mask_lsb;
   end

endmodule

// File: rtl/sampdriver_tdm.sv
// TDM sampling-clock generator: one channel per frame, round-robin over the enabled mask.
// `define SAMPDRV_BURST_EN adds burst_len/done for a fixed number of frames per start.
module sampdriver_tdm
   import sampdriver_pkg::*;
#(
   parameter int NCH   = DEF_NCH,
   parameter int CNT_W = DEF_CNT_W,
   parameter int DT_W  = DEF_DT_W
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] width,
   input  logic [DT_W-1:0]  dead,
   input  logic [NCH-1:0]   ch_en,
   output logic [NCH-1:0]   samp_out,
   output logic [NCH-1:0]   samp_out_b,
   output logic             frame_strobe,
   output logic             busy,
   output logic             cfg_err
`ifdef SAMPDRV_BURST_EN
   ,
   input  logic [CNT_W-1:0] burst_len,
   output logic             done
`endif
);

   localparam int               W1      = CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [W1-1:0]    W1_ONE  = W1'(1);

   state_e           state_q;
   logic [CNT_W-1:0] period_q, width_q, idx_q;
   logic [DT_W-1:0]  dead_q;
   logic [NCH-1:0]   mask_q, ptr_q, samp_q, samp_b_q;
   logic             strobe_q, busy_q, cfg_err_q;

   logic             idle, last_cycle, start_ok, start_arm, burst_hit;
   logic [CNT_W-1:0] idx_d, sel_idx, sel_width;
   logic [DT_W-1:0]  sel_dead;
   logic [NCH-1:0]   rr_mask, rr_cur, rr_next, ptr_d, sel_mask, samp_d, samp_b_d;
   logic [W1-1:0]    i_x, on_lo, on_hi, b_hi;

`ifdef SAMPDRV_BURST_EN
   logic [CNT_W-1:0] burst_q, fcnt_q;
   logic             arm_q, done_q;

   assign start_arm = arm_q;
   assign burst_hit = (burst_q != '0) && (fcnt_q == burst_q - CNT_ONE);
   assign done      = done_q;
`else
   assign start_arm = 1'b1;
   assign burst_hit = 1'b0;
`endif

   samp_rr_ptr #(.NCH(NCH)) u_rr (
      .mask_i (rr_mask),
      .cur_i  (rr_cur),
      .next_o (rr_next)
   );

   // In IDLE the outputs for frame cycle 0 are built from the live inputs about to be latched.
   always_comb begin
      idle       = (state_q == ST_IDLE);
      last_cycle = (idx_q == period_q);
      idx_d      = last_cycle ? '0 : idx_q + CNT_ONE;
      rr_mask    = idle ? ch_en : mask_q;
      rr_cur     = idle ? '0 : ptr_q;
      ptr_d      = (idle || last_cycle) ? rr_next : ptr_q;
      sel_idx    = idle ? '0 : idx_d;
      sel_width  = idle ? width : width_q;
      sel_dead   = idle ? dead : dead_q;
      sel_mask   = idle ? ch_en : mask_q;
      i_x        = W1'(sel_idx);
      on_lo      = W1'(sel_dead);
      on_hi      = on_lo + W1'(sel_width) - W1_ONE;
      b_hi       = on_hi + on_lo;
      samp_d     = ((i_x >= on_lo) && (i_x <= on_hi)) ? ptr_d : '0;
      samp_b_d   = sel_mask & ~((i_x <= b_hi) ? ptr_d : '0);
      start_ok   = en && start_arm &&
                   cfg_valid(32'(period), 32'(width), 32'(dead), |ch_en);
   end

   // NOTE: all state and output registers use <= so every update sees pre-edge values.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         period_q  <= '0;
         width_q   <= '0;
         dead_q    <= '0;
         mask_q    <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         samp_q    <= '0;
         samp_b_q  <= '0;
         strobe_q  <= 1'b0;
         busy_q    <= 1'b0;
         cfg_err_q <= 1'b0;
`ifdef SAMPDRV_BURST_EN
         burst_q   <= '0;
         fcnt_q    <= '0;
         arm_q     <= 1'b1;
         done_q    <= 1'b0;
`endif
      end else begin
         strobe_q <= 1'b0;
`ifdef SAMPDRV_BURST_EN
         done_q   <= 1'b0;
`endif
         unique case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  state_q   <= ST_RUN;
                  period_q  <= period;
                  width_q   <= width;
                  dead_q    <= dead;
                  mask_q    <= ch_en;
                  idx_q     <= '0;
                  ptr_q     <= ptr_d;
                  samp_q    <= samp_d;
                  samp_b_q  <= samp_b_d;
                  strobe_q  <= 1'b1;
                  busy_q    <= 1'b1;
                  cfg_err_q <= 1'b0;
`ifdef SAMPDRV_BURST_EN
                  burst_q   <= burst_len;
                  fcnt_q    <= '0;
`endif
               end else if (en && start_arm) begin
                  cfg_err_q <= 1'b1;
               end
`ifdef SAMPDRV_BURST_EN
               if (!en) arm_q <= 1'b1;
`endif
            end
            default: begin
               if (last_cycle && (!en || burst_hit)) begin
                  state_q  <= ST_IDLE;
                  samp_q   <= '0;
                  samp_b_q <= '0;
                  busy_q   <= 1'b0;
`ifdef SAMPDRV_BURST_EN
                  done_q   <= burst_hit;
                  if (burst_hit) arm_q <= 1'b0;
`endif
               end else begin
                  state_q  <= en ? ST_RUN : ST_STOP;
                  idx_q    <= idx_d;
                  ptr_q    <= ptr_d;
                  samp_q   <= samp_d;
                  samp_b_q <= samp_b_d;
                  strobe_q <= last_cycle;
`ifdef SAMPDRV_BURST_EN
                  if (last_cycle) fcnt_q <= fcnt_q + CNT_ONE;
`endif
               end
            end
         endcase
      end
   end

   assign samp_out     = samp_q;
   assign samp_out_b   = samp_b_q;
   assign frame_strobe = strobe_q;
   assign busy         = busy_q;
   assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_sampdriver_tdm.sv
// Scoreboard bench for sampdriver_tdm: a per-cycle model pushes expected output words, checked at negedge.
`timescale 1ns/1ps
module tb_sampdriver_tdm;

   localparam int NCH   = 4;
   localparam int CNT_W = 8;
   localparam int DT_W  = 3;

   typedef struct {
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] width;
      logic [DT_W-1:0]  dead;
      logic [NCH-1:0]   ch_en;
      int               frames;
      logic             valid;
   } vec_t;

   logic             clk_in;
   logic             rst;
   logic             en;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] width;
   logic [DT_W-1:0]  dead;
   logic [NCH-1:0]   ch_en;
   logic [NCH-1:0]   samp_out;
   logic [NCH-1:0]   samp_out_b;
   logic             frame_strobe;
   logic             busy;
   logic             cfg_err;
   logic             done;
`ifdef SAMPDRV_BURST_EN
   logic [CNT_W-1:0] burst_len;
`endif

   int          checks;
   int          failures;
   logic [31:0] exp_q[$];
   logic        exp_err;
   vec_t        tbl[11];
   vec_t        basic_v;
   vec_t        fix_v;
   vec_t        burst_v;

   sampdriver_tdm #(.NCH(NCH), .CNT_W(CNT_W), .DT_W(DT_W)) dut (
      .clk_in       (clk_in),
      .rst          (rst),
      .en           (en),
      .period       (period),
      .width        (width),
      .dead         (dead),
      .ch_en        (ch_en),
      .samp_out     (samp_out),
      .samp_out_b   (samp_out_b),
      .frame_strobe (frame_strobe),
      .busy         (busy),
      .cfg_err      (cfg_err)
`ifdef SAMPDRV_BURST_EN
      ,
      .burst_len    (burst_len),
      .done         (done)
`endif
   );

`ifndef SAMPDRV_BURST_EN
   assign done = 1'b0;
`endif

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t act=%h req=%h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic d, input logic e, input logic b, input logic f,
                                        input logic [NCH-1:0] sb, input logic [NCH-1:0] so);
      return 32'({d, e, b, f, sb, so});
   endfunction

   // Expected output word for cycle k after a start with configuration v.
   function automatic logic [31:0] run_word(input vec_t v, input int k);
      int p, f, i, n, sel, dd, ww;
      int chs[NCH];
      logic [NCH-1:0] so, sb;
      p  = int'(v.period) + 1;
      f  = k / p;
      i  = k % p;
      dd = int'(v.dead);
      ww = int'(v.width);
      n  = 0;
      for (int j = 0; j < NCH; j++) begin
         chs[j] = 0;
         if (v.ch_en[j]) begin
            chs[n] = j;
            n++;
         end
      end
      sel = chs[f % n];
      so  = '0;
      sb  = '0;
      for (int j = 0; j < NCH; j++) begin
         if (v.ch_en[j]) begin
            if (j == sel) begin
               so[j] = (i >= dd) && (i < dd + ww);
               sb[j] = (i >= 2 * dd + ww);
            end else begin
               sb[j] = 1'b1;
            end
         end
      end
      return pack(1'b0, 1'b0, 1'b1, (i == 0), sb, so);
   endfunction

   task automatic push_run(input vec_t v, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(run_word(v, k));
   endtask

   task automatic push_idle(input int n, input logic d);
      for (int k = 0; k < n; k++) exp_q.push_back(pack(d, exp_err, 1'b0, 1'b0, '0, '0));
   endtask

   task automatic apply(input vec_t v);
      period = v.period;
      width  = v.width;
      dead   = v.dead;
      ch_en  = v.ch_en;
   endtask

   task automatic cycle_check(input string name);
      logic [31:0] act;
      logic [31:0] exp;
      @(negedge clk_in);
      act = pack(done, cfg_err, busy, frame_strobe, samp_out_b, samp_out);
      check({name, "_nonovl"}, 32'(samp_out & samp_out_b), 32'd0);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s scoreboard_empty act=%h req=queued_word", name, act);
      end else begin
         exp = exp_q.pop_front();
         check(name, act, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      exp_err  = 1'b0;
      //               period  width  dead  ch_en    frames valid
      tbl[0]  = '{8'd9,   8'd3, 3'd1, 4'b1111, 5, 1'b1};
      tbl[1]  = '{8'd9,   8'd3, 3'd1, 4'b1010, 3, 1'b1};
      tbl[2]  = '{8'd0,   8'd1, 3'd0, 4'b0111, 6, 1'b1};
      tbl[3]  = '{8'd7,   8'd5, 3'd2, 4'b1111, 0, 1'b0};
      tbl[4]  = '{8'd5,   8'd2, 3'd0, 4'b1001, 3, 1'b1};
      tbl[5]  = '{8'd9,   8'd0, 3'd1, 4'b1111, 0, 1'b0};
      tbl[6]  = '{8'd7,   8'd4, 3'd2, 4'b0100, 2, 1'b1};
      tbl[7]  = '{8'd9,   8'd3, 3'd1, 4'b0000, 0, 1'b0};
      tbl[8]  = '{8'd0,   8'd1, 3'd1, 4'b0001, 0, 1'b0};
      tbl[9]  = '{8'd3,   8'd1, 3'd1, 4'b0001, 3, 1'b1};
      tbl[10] = '{8'd255, 8'd1, 3'd7, 4'b1000, 1, 1'b1};
      basic_v = tbl[0];
      fix_v   = '{8'd9, 8'd4, 3'd2, 4'b1111, 1, 1'b1};
      burst_v = '{8'd3, 8'd1, 3'd0, 4'b0011, 3, 1'b1};

`ifdef SAMPDRV_BURST_EN
      burst_len = '0;
`endif
      // Reset held with en high, then the first frame right after release.
      rst = 1'b1;
      en  = 1'b1;
      apply(basic_v);
      push_idle(3, 1'b0);
      repeat (3) cycle_check("reset");
      rst = 1'b0;
      push_run(basic_v, 10);
      push_idle(1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         cycle_check("first_frame");
         if (k == 9) en = 1'b0;
      end
      cycle_check("first_idle");

      // Table: valid configs run their frames with scrambled inputs; invalid ones must be rejected.
      for (int t = 0; t < 11; t++) begin
         apply(tbl[t]);
         en = 1'b1;
         if (tbl[t].valid) begin
            int n;
            n = (int'(tbl[t].period) + 1) * tbl[t].frames;
            push_run(tbl[t], n);
            exp_err = 1'b0;
            push_idle(1, 1'b0);
            for (int k = 0; k < n; k++) begin
               cycle_check($sformatf("vec%0d", t));
               if (k == 0) begin
                  period = CNT_W'($urandom);
                  width  = CNT_W'($urandom);
                  dead   = DT_W'($urandom);
                  ch_en  = NCH'($urandom);
               end
               if (k == n - 1) en = 1'b0;
            end
            cycle_check($sformatf("vec%0d_idle", t));
         end else begin
            exp_err = 1'b1;
            push_idle(2, 1'b0);
            repeat (2) cycle_check($sformatf("vec%0d_err", t));
            en = 1'b0;
            push_idle(1, 1'b0);
            cycle_check($sformatf("vec%0d_hold", t));
         end
      end

      // Config error then correction.
      apply(basic_v);
      width   = 8'd8;
      dead    = 3'd2;
      en      = 1'b1;
      exp_err = 1'b1;
      push_idle(3, 1'b0);
      repeat (3) cycle_check("cfg_err");
      width   = 8'd4;
      push_run(fix_v, 10);
      exp_err = 1'b0;
      push_idle(1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         cycle_check("cfg_fix");
         if (k == 9) en = 1'b0;
      end
      cycle_check("cfg_fix_idle");

      // en dropped at i=4: the frame still completes.
      apply(basic_v);
      en = 1'b1;
      push_run(basic_v, 10);
      push_idle(1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         cycle_check("stop_mid");
         if (k == 4) en = 1'b0;
      end
      cycle_check("stop_idle");

      // en dropped then reasserted inside the frame: no gap.
      en = 1'b1;
      push_run(basic_v, 20);
      push_idle(1, 1'b0);
      for (int k = 0; k < 20; k++) begin
         cycle_check("stop_resume");
         if (k == 3)  en = 1'b0;
         if (k == 6)  en = 1'b1;
         if (k == 19) en = 1'b0;
      end
      cycle_check("resume_idle");

      // Reset at i=2 of the second frame.
      en = 1'b1;
      push_run(basic_v, 13);
      for (int k = 0; k < 13; k++) cycle_check("rst_mid_run");
      rst = 1'b1;
      push_idle(1, 1'b0);
      cycle_check("rst_mid");
      rst = 1'b0;
      en  = 1'b0;
      push_idle(1, 1'b0);
      cycle_check("rst_after");

`ifdef SAMPDRV_BURST_EN
      // Burst of 3 frames, no restart until en is seen low.
      apply(burst_v);
      burst_len = 8'd3;
      en = 1'b1;
      push_run(burst_v, 12);
      push_idle(1, 1'b1);
      push_idle(4, 1'b0);
      repeat (17) cycle_check("burst");
      en = 1'b0;
      push_idle(1, 1'b0);
      cycle_check("burst_low");
      en = 1'b1;
      push_run(burst_v, 12);
      push_idle(1, 1'b1);
      repeat (13) cycle_check("burst_again");
      en = 1'b0;
      burst_len = '0;
      push_idle(1, 1'b0);
      cycle_check("burst_end");
`endif

      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_leftover act=%0d req=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
